// File: rtl/ft245_dev_model_if.sv
// FT245R-style FIFO bus between ftdi_fifo (master) and the device model (slave).
interface ft245_dev_model_if;
  logic       rxf_n;
  logic       rd_n;
  logic [7:0] rx_data;
  logic       rx_oe;
  logic       txe_n;
  logic       wr_n;
  logic [7:0] tx_data;

  modport master (input rxf_n, rx_data, rx_oe, txe_n, output rd_n, wr_n, tx_data);
  modport slave  (output rxf_n, rx_data, rx_oe, txe_n, input rd_n, wr_n, tx_data);
endinterface

// File: rtl/ft245_dev_model.sv
// Clocked FT245R device model: sources an incrementing RX byte stream and
// captures written TX bytes into a FIFO drained by the host side.
module ft245_dev_model #(
  parameter int DEPTH    = 16,
  parameter int RX_COUNT = 256,
  parameter int RX_GAP   = 2,
  parameter int TX_GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ft245_dev_model_if.slave         bus,
  input  logic                     drain,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     rx_done,
  output logic [2:0]               err
);
  localparam int          AW          = $clog2(DEPTH);
  localparam logic [15:0] RX_LAST     = 16'(RX_COUNT);
  localparam logic [15:0] RX_GAP_LOAD = 16'(RX_GAP - 1);
  localparam logic [15:0] TX_GAP_LOAD = 16'(TX_GAP - 1);

  typedef enum logic [1:0] {RXS_AVAIL, RXS_READ, RXS_GAP, RXS_DONE} rx_state_t;
  typedef enum logic [1:0] {TXS_READY, TXS_WRITE, TXS_GAP} tx_state_t;

  rx_state_t   rx_state_reg, rx_state_next;
  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [15:0] rx_gap_reg, rx_gap_next;
  logic [15:0] tx_gap_reg, tx_gap_next;
  logic [2:0]  err_reg, err_next;
  logic        rd_q_reg, wr_q_reg;
  logic [AW:0] wptr_reg, rptr_reg;
  logic        tx_valid_reg;
  logic [7:0]  tx_data_reg;
  logic [7:0]  mem [DEPTH];

  logic rd_fall, rd_rise, wr_fall, wr_rise;
  logic full, empty, push, pop;
  logic rx_err, tx_err_proto, tx_err_full;

  assign rd_fall = rd_q_reg & ~bus.rd_n;
  assign rd_rise = ~rd_q_reg & bus.rd_n;
  assign wr_fall = wr_q_reg & ~bus.wr_n;
  assign wr_rise = ~wr_q_reg & bus.wr_n;

  assign full  = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign empty = (wptr_reg == rptr_reg);
  assign pop   = drain & ~empty;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_gap_next   = rx_gap_reg;
    rx_err        = 1'b0;
    case (rx_state_reg)
      RXS_AVAIL: if (rd_fall) rx_state_next = RXS_READ;
      RXS_READ: begin
        if (rd_rise) begin
          rx_cnt_next = rx_cnt_reg + 16'd1;
          if (rx_cnt_next == RX_LAST) begin
            rx_state_next = RXS_DONE;
          end else begin
            rx_state_next = RXS_GAP;
            rx_gap_next   = RX_GAP_LOAD;
          end
        end
      end
      RXS_GAP: begin
        rx_err = rd_fall;
        if (rx_gap_reg == 16'd0) rx_state_next = RXS_AVAIL;
        else                     rx_gap_next   = rx_gap_reg - 16'd1;
      end
      RXS_DONE: rx_err = rd_fall;
      default:  rx_state_next = RXS_AVAIL;
    endcase
  end

  // A fall while full is refused outright, even if a pop frees a slot this cycle.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_gap_next   = tx_gap_reg;
    push          = 1'b0;
    tx_err_proto  = 1'b0;
    tx_err_full   = 1'b0;
    case (tx_state_reg)
      TXS_READY: begin
        if (wr_fall) begin
          if (full) begin
            tx_err_full = 1'b1;
          end else begin
            push          = 1'b1;
            tx_state_next = TXS_WRITE;
          end
        end
      end
      TXS_WRITE: begin
        if (wr_fall) begin
          tx_err_proto = 1'b1;
        end else if (wr_rise) begin
          tx_state_next = TXS_GAP;
          tx_gap_next   = TX_GAP_LOAD;
        end
      end
      TXS_GAP: begin
        tx_err_proto = wr_fall;
        if (tx_gap_reg == 16'd0) tx_state_next = TXS_READY;
        else                     tx_gap_next   = tx_gap_reg - 16'd1;
      end
      default: tx_state_next = TXS_READY;
    endcase
  end

  assign err_next = err_reg | {tx_err_full, tx_err_proto, rx_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RXS_AVAIL;
      tx_state_reg <= TXS_READY;
      rx_cnt_reg   <= '0;
      rx_gap_reg   <= '0;
      tx_gap_reg   <= '0;
      err_reg      <= '0;
      rd_q_reg     <= 1'b1;
      wr_q_reg     <= 1'b1;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      tx_state_reg <= tx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_gap_reg   <= rx_gap_next;
      tx_gap_reg   <= tx_gap_next;
      err_reg      <= err_next;
      rd_q_reg     <= bus.rd_n;
      wr_q_reg     <= bus.wr_n;
      tx_valid_reg <= pop;
      if (push) wptr_reg <= wptr_reg + 1'b1;
      if (pop) begin
        rptr_reg    <= rptr_reg + 1'b1;
        tx_data_reg <= mem[rptr_reg[AW-1:0]];
      end
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg[AW-1:0]] <= bus.tx_data;
  end

  assign bus.rxf_n   = (rx_state_reg == RXS_GAP) || (rx_state_reg == RXS_DONE);
  assign bus.rx_data = rx_cnt_reg[7:0];
  assign bus.rx_oe   = ~bus.rd_n;
  assign bus.txe_n   = (tx_state_reg == TXS_READY) ? full : 1'b1;
  assign tx_valid    = tx_valid_reg;
  assign tx_data     = tx_data_reg;
  assign tx_level    = wptr_reg - rptr_reg;
  assign rx_done     = (rx_state_reg == RXS_DONE);
  assign err         = err_reg;
endmodule

// File: tb/tb_ft245_dev_model.sv
// Directed bench for ft245_dev_model: RX stream, TX capture/drain, errors, reset.
module tb_ft245_dev_model;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       drain;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [2:0] tx_level;
  logic       rx_done;
  logic [2:0] err;
  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         fail_cnt = 0;

  ft245_dev_model_if bus ();

  ft245_dev_model #(.DEPTH(4), .RX_COUNT(4), .RX_GAP(2), .TX_GAP(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drain    (drain),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_level (tx_level),
    .rx_done  (rx_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rxf_n"},    16'(bus.rxf_n),   16'd0);
    chk({tag, "_rx_data"},  16'(bus.rx_data), 16'h00);
    chk({tag, "_txe_n"},    16'(bus.txe_n),   16'd0);
    chk({tag, "_tx_valid"}, 16'(tx_valid),    16'd0);
    chk({tag, "_tx_data"},  16'(tx_data),     16'h00);
    chk({tag, "_level"},    16'(tx_level),    16'd0);
    chk({tag, "_rx_done"},  16'(rx_done),     16'd0);
    chk({tag, "_err"},      16'(err),         16'd0);
  endtask

  // RD_n low for three edges, then high; RXF_n must stay high two cycles.
  task automatic rx_read(input logic [7:0] exp);
    chk("rx_avail", 16'(bus.rxf_n), 16'd0);
    chk("rx_data", 16'(bus.rx_data), 16'(exp));
    bus.rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rx_oe", 16'(bus.rx_oe), 16'd1);
      chk("rx_hold", 16'(bus.rx_data), 16'(exp));
      chk("rx_rxf_low", 16'(bus.rxf_n), 16'd0);
    end
    bus.rd_n = 1'b1;
    step();
    chk("rxf_after_rise", 16'(bus.rxf_n), 16'd1);
    chk("rx_next", 16'(bus.rx_data), 16'(exp) + 16'd1);
    step();
    chk("rxf_gap", 16'(bus.rxf_n), 16'd1);
    step();
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.tx_data = d;
    bus.wr_n    = 1'b0;
    step();
    chk("txe_busy", 16'(bus.txe_n), 16'd1);
    bus.wr_n = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic pop_one(input logic [7:0] d, input logic [15:0] lvl);
    drain = 1'b1;
    step();
    chk("pop_valid", 16'(tx_valid), 16'd1);
    chk("pop_data", 16'(tx_data), 16'(d));
    chk("pop_level", 16'(tx_level), lvl);
  endtask

  initial begin
    rst_n       = 1'b0;
    drain       = 1'b0;
    bus.rd_n    = 1'b1;
    bus.wr_n    = 1'b1;
    bus.tx_data = 8'h00;
    step();
    step();
    check_reset("por");
    rst_n = 1'b1;
    step();

    // RX stream of four bytes, then done and an illegal extra read
    rx_read(8'h00);
    rx_read(8'h01);
    rx_read(8'h02);
    rx_read(8'h03);
    chk("rx_done", 16'(rx_done), 16'd1);
    step();
    chk("rxf_stays_high", 16'(bus.rxf_n), 16'd1);
    bus.rd_n = 1'b0;
    step();
    chk("err_rd_done", 16'(err), 16'b001);
    chk("rxf_done_fall", 16'(bus.rxf_n), 16'd1);
    bus.rd_n = 1'b1;
    step();

    // TX write and drain
    tx_write(8'hA5);
    chk("lvl_1", 16'(tx_level), 16'd1);
    tx_write(8'h3C);
    chk("lvl_2", 16'(tx_level), 16'd2);
    chk("txe_ready", 16'(bus.txe_n), 16'd0);
    pop_one(8'hA5, 16'd1);
    pop_one(8'h3C, 16'd0);
    drain = 1'b0;
    step();
    chk("valid_pulse_end", 16'(tx_valid), 16'd0);

    // Fill, overflow attempt, drain
    tx_write(8'h11);
    tx_write(8'h22);
    tx_write(8'h33);
    tx_write(8'h44);
    chk("full_level", 16'(tx_level), 16'd4);
    chk("full_txe", 16'(bus.txe_n), 16'd1);
    bus.tx_data = 8'h99;
    bus.wr_n    = 1'b0;
    step();
    chk("err_overflow", 16'(err), 16'b101);
    chk("overflow_level", 16'(tx_level), 16'd4);
    bus.wr_n = 1'b1;
    step();
    pop_one(8'h11, 16'd3);
    pop_one(8'h22, 16'd2);
    pop_one(8'h33, 16'd1);
    pop_one(8'h44, 16'd0);
    drain = 1'b0;
    step();
    chk("txe_after_drain", 16'(bus.txe_n), 16'd0);

    // Write strobe during the gap
    bus.tx_data = 8'h55;
    bus.wr_n    = 1'b0;
    step();
    bus.wr_n = 1'b1;
    step();
    bus.tx_data = 8'hAA;
    bus.wr_n    = 1'b0;
    step();
    chk("err_proto", 16'(err), 16'b111);
    chk("proto_level", 16'(tx_level), 16'd1);
    bus.wr_n = 1'b1;
    step();
    chk("txe_after_gap", 16'(bus.txe_n), 16'd0);

    // Simultaneous push and pop at level 2
    tx_write(8'h66);
    chk("pre_sim_level", 16'(tx_level), 16'd2);
    bus.tx_data = 8'h77;
    bus.wr_n    = 1'b0;
    drain       = 1'b1;
    step();
    chk("sim_valid", 16'(tx_valid), 16'd1);
    chk("sim_data", 16'(tx_data), 16'h55);
    chk("sim_level", 16'(tx_level), 16'd2);
    drain    = 1'b0;
    bus.wr_n = 1'b1;
    step();
    step();
    step();
    pop_one(8'h66, 16'd1);
    pop_one(8'h77, 16'd0);
    drain = 1'b0;
    step();

    // Reset in the middle of an RX read
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rx_back_avail", 16'(bus.rxf_n), 16'd0);
    tx_write(8'h88);
    chk("pre_rst_level", 16'(tx_level), 16'd1);
    bus.rd_n = 1'b0;
    step();
    chk("pre_rst_oe", 16'(bus.rx_oe), 16'd1);
    #2;
    rst_n    = 1'b0;
    bus.rd_n = 1'b1;
    #1;
    check_reset("mid");
    step();
    rst_n = 1'b1;
    step();
    rx_read(8'h00);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
